// File: rtl/cache_pkg.sv
// Word/byte geometry shared by the cache data arrays.
package cache_pkg;
  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int line_w(input int words);
    return WORD_W * words;
  endfunction

  function automatic int lanes_per_line(input int words);
    return BYTES_PER_WORD * words;
  endfunction
endpackage

// File: rtl/simple_dual_wf.sv
// Simple dual-port RAM: one byte-masked write port, one registered read port.
// Contents are never reset.
module simple_dual_wf #(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                         clk,
  input  logic [NUM_COL-1:0]           wea_i,
  input  logic [ADDR_WIDTH-1:0]        addra_i,
  input  logic [NUM_COL*COL_WIDTH-1:0] dia_i,
  input  logic                         enb_i,
  input  logic [ADDR_WIDTH-1:0]        addrb_i,
  output logic [NUM_COL*COL_WIDTH-1:0] dob_o
);
  localparam int DATA_W = NUM_COL * COL_WIDTH;
  localparam int DEPTH  = 1 << ADDR_WIDTH;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dob_q;

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_COL; c++) begin
      if (wea_i[c]) mem_q[addra_i][c*COL_WIDTH +: COL_WIDTH] <= dia_i[c*COL_WIDTH +: COL_WIDTH];
    end
  end

  // A same-address read samples mem_q before the write lands: old data out.
  always_ff @(posedge clk) begin
    if (enb_i) dob_q <= mem_q[addrb_i];
  end

  assign dob_o = dob_q;
endmodule

// File: rtl/data_way_array.sv
// NWAY-way cache data array with 1-cycle reads and stall hold.
// DATA_WAY_ARRAY_FWD_EN adds write forwarding on collisions and into held rdata.
module data_way_array
  import cache_pkg::*;
#(
  parameter int LINE  = 128,
  parameter int BLOCK = 8,
  parameter int NWAY  = 2
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 ren,
  input  logic                                 stall,
  input  logic [index_w(LINE)-1:0]             rindex,
  input  logic [NWAY*lanes_per_line(BLOCK)-1:0] wen,
  input  logic [index_w(LINE)-1:0]             windex,
  input  logic [line_w(BLOCK)-1:0]             wdata,
  output logic [NWAY*line_w(BLOCK)-1:0]        rdata,
  output logic                                 rvalid
);
  localparam int IDX_W = index_w(LINE);
  localparam int LANES = lanes_per_line(BLOCK);
  localparam int LW    = line_w(BLOCK);

  logic                 rd_accept;
  logic                 rvalid_q, rvalid_d;
  logic [NWAY*LW-1:0]   ram_line;

  assign rd_accept = ren & ~stall;

  genvar gi;
  for (gi = 0; gi < NWAY; gi++) begin : g_way
    simple_dual_wf #(
      .NUM_COL   (LANES),
      .COL_WIDTH (BYTE_W),
      .ADDR_WIDTH(IDX_W)
    ) u_way (
      .clk    (clk),
      .wea_i  (wen[gi*LANES +: LANES]),
      .addra_i(windex),
      .dia_i  (wdata),
      .enb_i  (rd_accept),
      .addrb_i(rindex),
      .dob_o  (ram_line[gi*LW +: LW])
    );
  end

  always_comb begin
    rvalid_d = rvalid_q;
    if (!stall) rvalid_d = ren;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rvalid_q <= 1'b0;
    else         rvalid_q <= rvalid_d;
  end

  assign rvalid = rvalid_q;

`ifdef DATA_WAY_ARRAY_FWD_EN
  localparam int NBYTES = NWAY * LANES;

  logic [IDX_W-1:0]              rindex_q, rindex_d;
  logic [NBYTES-1:0]             fwd_mask_q, fwd_mask_d;
  logic [NBYTES-1:0][BYTE_W-1:0] fwd_byte_q, fwd_byte_d;
  logic [NBYTES-1:0][BYTE_W-1:0] merged;
  logic                          collide, hold_merge;

  assign rindex_d   = rd_accept ? rindex : rindex_q;
  assign collide    = rd_accept & (rindex == windex);
  assign hold_merge = stall & rvalid_q & (windex == rindex_q);

  // Flat byte k is way k/LANES, lane k%LANES, matching both wen and rdata.
  for (gi = 0; gi < NBYTES; gi++) begin : g_fwd
    logic [BYTE_W-1:0] wbyte;
    assign wbyte          = wdata[(gi % LANES)*BYTE_W +: BYTE_W];
    assign fwd_mask_d[gi] = rd_accept ? (collide & wen[gi])
                                      : (fwd_mask_q[gi] | (hold_merge & wen[gi]));
    assign fwd_byte_d[gi] = (rd_accept | (hold_merge & wen[gi])) ? wbyte : fwd_byte_q[gi];
    assign merged[gi]     = fwd_mask_q[gi] ? fwd_byte_q[gi] : ram_line[gi*BYTE_W +: BYTE_W];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rindex_q   <= '0;
      fwd_mask_q <= '0;
      fwd_byte_q <= '0;
    end else begin
      rindex_q   <= rindex_d;
      fwd_mask_q <= fwd_mask_d;
      fwd_byte_q <= fwd_byte_d;
    end
  end

  assign rdata = rvalid_q ? merged : '0;
`else
  assign rdata = rvalid_q ? ram_line : '0;
`endif
endmodule

// File: tb/tb_data_way_array.sv
// Scoreboard bench for data_way_array with a byte-level reference model.
module tb_data_way_array;
  localparam int LINE   = 128;
  localparam int BLOCK  = 8;
  localparam int NWAY   = 4;
  localparam int IDX_W  = 7;
  localparam int LANES  = 4 * BLOCK;
  localparam int LW     = 32 * BLOCK;
  localparam int NBYTES = NWAY * LANES;
  localparam int RW     = NWAY * LW;

  logic              clk    = 1'b0;
  logic              resetn = 1'b0;
  logic              ren    = 1'b0;
  logic              stall  = 1'b0;
  logic [IDX_W-1:0]  rindex = '0;
  logic [IDX_W-1:0]  windex = '0;
  logic [NBYTES-1:0] wen    = '0;
  logic [LW-1:0]     wdata  = '0;
  logic [RW-1:0]     rdata;
  logic              rvalid;

  data_way_array #(.LINE(LINE), .BLOCK(BLOCK), .NWAY(NWAY)) dut (
    .clk   (clk),
    .resetn(resetn),
    .ren   (ren),
    .stall (stall),
    .rindex(rindex),
    .wen   (wen),
    .windex(windex),
    .wdata (wdata),
    .rdata (rdata),
    .rvalid(rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            valid;
    bit            zero;
    logic [RW-1:0] data;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  int    n_cmp = 0;
  int    n_bad = 0;
  string tag   = "reset";

  // Reference model: array contents and the line the output should show.
  logic [7:0] mem_m [NWAY][LINE][LANES];
  logic [7:0] m_out [NBYTES];
  bit         m_valid = 1'b0;
  int         m_idx   = 0;

  task automatic model_edge();
    exp_t e;
    if (!resetn) begin
      m_valid = 1'b0;
      for (int k = 0; k < NBYTES; k++) m_out[k] = 8'h00;
      e.valid = 1'b0;
      e.zero  = 1'b1;
      e.data  = '0;
    end else begin
      if (ren && !stall) begin
        for (int w = 0; w < NWAY; w++) begin
          for (int j = 0; j < LANES; j++) begin
            m_out[w*LANES+j] = mem_m[w][rindex][j];
`ifdef DATA_WAY_ARRAY_FWD_EN
            if (rindex == windex && wen[w*LANES+j]) m_out[w*LANES+j] = wdata[j*8 +: 8];
`endif
          end
        end
        m_valid = 1'b1;
        m_idx   = int'(rindex);
      end else if (!stall) begin
        m_valid = 1'b0;
      end
`ifdef DATA_WAY_ARRAY_FWD_EN
      else if (m_valid && int'(windex) == m_idx) begin
        for (int k = 0; k < NBYTES; k++)
          if (wen[k]) m_out[k] = wdata[(k % LANES)*8 +: 8];
      end
`endif
      for (int w = 0; w < NWAY; w++)
        for (int j = 0; j < LANES; j++)
          if (wen[w*LANES+j]) mem_m[w][windex][j] = wdata[j*8 +: 8];
      e.valid = m_valid;
      e.zero  = 1'b0;
      e.data  = '0;
      for (int k = 0; k < NBYTES; k++) e.data[k*8 +: 8] = m_out[k];
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Asynchronous reset lands mid-cycle, so the pending expectation becomes zero.
  task automatic assert_reset_now();
    exp_t z;
    resetn  = 1'b0;
    m_valid = 1'b0;
    z.valid = 1'b0;
    z.zero  = 1'b1;
    z.data  = '0;
    if (exp_q.size() != 0) exp_q[exp_q.size()-1] = z;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW/32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [IDX_W-1:0] rand_idx();
    if ($urandom_range(0, 3) == 0) return IDX_W'($urandom_range(0, LINE-1));
    return IDX_W'($urandom_range(0, 3));
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      if (rvalid !== mon_e.valid) begin
        n_bad++;
        $display("FAIL %s rvalid got %0b exp %0b at t=%0t", tag, rvalid, mon_e.valid, $time);
      end else if (mon_e.valid || mon_e.zero) begin
        for (int w = 0; w < NWAY; w++) begin
          n_cmp++;
          if (rdata[w*LW +: LW] !== mon_e.data[w*LW +: LW]) begin
            n_bad++;
            $display("FAIL %s way%0d rdata got %h exp %h", tag, w, rdata[w*LW +: LW], mon_e.data[w*LW +: LW]);
          end
        end
        if (mon_e.valid) $display("t=%0t %s read checked", $time, tag);
      end
    end else if (rvalid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s unexpected rvalid got 1 exp none at t=%0t", tag, $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    resetn = 1'b1;

    tag = "fill";
    for (int i = 0; i < LINE; i++) begin
      windex = IDX_W'(i);
      wen    = '1;
      wdata  = rand_line();
      tick();
    end
    wen = '0;

    tag = "basic_read";
    windex = 7'd5; wen = '0; wen[0 +: LANES] = {LANES{1'b1}}; wdata = {LANES{8'h11}};
    tick();
    wen = '0; ren = 1'b1; rindex = 7'd5;
    tick();
    ren = 1'b0;
    tick();

    tag = "collision";
    ren = 1'b1; rindex = 7'd5; windex = 7'd5; wdata = {LANES{8'hAA}};
    wen = '0; wen[7:0] = 8'hFF;
    tick();
    ren = 1'b0; wen = '0;
    tick();

    tag = "stall_hold";
    windex = 7'd3; wen = '0; wen[LANES +: LANES] = {LANES{1'b1}}; wdata = {LANES{8'h22}};
    tick();
    wen = '0; ren = 1'b1; rindex = 7'd3;
    tick();
    ren = 1'b0; stall = 1'b1; windex = 7'd3; wen = '0; wen[LANES] = 1'b1;
    wdata = '0; wdata[7:0] = 8'h7F;
    tick();
    tag = "stall_other";
    windex = 7'd4; wen = '1; wdata = rand_line();
    tick();
    wen = '0;
    tick();
    tick();
    stall = 1'b0; ren = 1'b1; rindex = 7'd4;
    tick();
    rindex = 7'd3;
    tick();
    ren = 1'b0;
    tick();

    tag = "back_to_back";
    ren = 1'b1; rindex = 7'd0;
    tick();
    rindex = 7'd127;
    tick();
    rindex = 7'd0;
    tick();
    ren = 1'b0;
    tick();

    tag = "reset_inflight";
    ren = 1'b1; rindex = 7'd9;
    tick();
    ren = 1'b0;
    assert_reset_now();
    tick();
    tick();
    resetn = 1'b1;
    tick();
    tick();
    ren = 1'b1; rindex = 7'd9;
    tick();
    ren = 1'b0;
    tick();

    tag = "random";
    repeat (600) begin
      ren    = ($urandom_range(0, 3) != 0);
      stall  = ($urandom_range(0, 3) == 0);
      rindex = rand_idx();
      windex = rand_idx();
      wen    = '0;
      if ($urandom_range(0, 1) == 1)
        for (int k = 0; k < NBYTES; k++) wen[k] = ($urandom_range(0, 2) == 0);
      wdata = rand_line();
      tick();
    end

    tag = "drain";
    ren = 1'b0; stall = 1'b0; wen = '0;
    tick();
    tick();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain queue got %0d left exp 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
